sprite_ram_loader: RTL and testbench

Write-side companion of the sprite source: decodes a run-length-encoded pixel stream and drives the sprite RAM write port (`we`, `addr_w`, `pixel_in`) so that a 32×64, 12-bit card-back or other sprite can be reloaded at run time. It sits between a word source, such as a ROM reader or a bus FIFO, and the sprite source's RAM write inputs. Addresses follow the sprite read order `{y[5:0], x[4:0]}`, which is linear row-major from 0 to 2^ADDR−1.

---
 rtl/sprite_ram_loader.sv | 185 ++++++++++++++++++
 tb/tb_sprite_ram_loader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_ram_loader.sv
// Purpose: decode a {run, color} RLE word stream into sprite RAM writes, row-major from address 0.
// Latency: one cycle from an accepted word (or start) to the registered we/addr_w/pixel_out.
// Backpressure: s_ready drops while a run is expanded or outside a load; words are only taken in LOAD.
// Build option: define SPRITE_LOADER_PAD_EN to fill the rest of the frame with KEY_COLOR after an early s_last.
module sprite_ram_loader #(
    parameter int CD        = 12,
    parameter int ADDR      = 11,
    parameter int RUN_W     = 5,
    parameter int KEY_COLOR = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [RUN_W+CD-1:0] s_data,
    input  logic                s_last,
    output logic                we,
    output logic [ADDR-1:0]     addr_w,
    output logic [CD-1:0]       pixel_out,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [ADDR-1:0] LAST_ADDR = '1;
`ifdef SPRITE_LOADER_PAD_EN
    localparam logic [CD-1:0]   KEY_C     = CD'(KEY_COLOR);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXPAND,
`ifdef SPRITE_LOADER_PAD_EN
        S_PAD,
`endif
        S_DONE
    } state_t;

    state_t           state, state_d;
    logic [ADDR-1:0]  ptr, ptr_d;
    logic [RUN_W-1:0] rem, rem_d;
    logic [CD-1:0]    color_q, color_d;
    logic             last_q, last_d;
    logic             s_ready_d, we_d, busy_d, done_d, err_d;
    logic [ADDR-1:0]  addr_d;
    logic [CD-1:0]    pix_d;

    logic [RUN_W-1:0] s_run;
    logic [CD-1:0]    s_color;
    assign s_run   = s_data[CD +: RUN_W];
    assign s_color = s_data[CD-1:0];

    // State and every output are registered; reset is synchronous.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            rem       <= '0;
            color_q   <= '0;
            last_q    <= 1'b0;
            s_ready   <= 1'b0;
            we        <= 1'b0;
            addr_w    <= '0;
            pixel_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            rem       <= rem_d;
            color_q   <= color_d;
            last_q    <= last_d;
            s_ready   <= s_ready_d;
            we        <= we_d;
            addr_w    <= addr_d;
            pixel_out <= pix_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

    // Next state plus the values the output registers take at the coming edge.
    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        rem_d     = rem;
        color_d   = color_q;
        last_d    = last_q;
        s_ready_d = 1'b0;
        we_d      = 1'b0;
        addr_d    = addr_w;
        pix_d     = pixel_out;
        busy_d    = (state != S_IDLE);
        done_d    = 1'b0;
        err_d     = err;
        case (state)
            S_IDLE: begin
                // busy is still high during the done cycle, so a start there is dropped
                if (start && !busy) begin
                    state_d   = S_LOAD;
                    ptr_d     = '0;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    s_ready_d = 1'b1;
                end
            end
            S_LOAD: begin
                s_ready_d = 1'b1;
                if (s_valid && s_ready) begin
                    we_d    = 1'b1;
                    addr_d  = ptr;
                    pix_d   = s_color;
                    color_d = s_color;
                    rem_d   = s_run;
                    last_d  = s_last;
                    if (ptr == LAST_ADDR) begin
                        // frame full: a missing s_last or leftover run pixels are errors
                        if (!s_last || (s_run != '0)) err_d = 1'b1;
                        state_d   = S_DONE;
                        s_ready_d = 1'b0;
                    end else begin
                        ptr_d = ptr + 1'b1;
                        if (s_run != '0) begin
                            state_d   = S_EXPAND;
                            s_ready_d = 1'b0;
                        end else if (s_last) begin
                            s_ready_d = 1'b0;
`ifdef SPRITE_LOADER_PAD_EN
                            state_d   = S_PAD;
`else
                            err_d     = 1'b1;
                            state_d   = S_DONE;
`endif
                        end
                    end
                end
            end
            S_EXPAND: begin
                // rem counts the writes still owed by the latched word
                we_d   = 1'b1;
                addr_d = ptr;
                pix_d  = color_q;
                rem_d  = rem - RUN_W'(1);
                if (ptr == LAST_ADDR) begin
                    if (!last_q || (rem != RUN_W'(1))) err_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    ptr_d = ptr + 1'b1;
                    if (rem == RUN_W'(1)) begin
                        if (last_q) begin
`ifdef SPRITE_LOADER_PAD_EN
                            state_d = S_PAD;
`else
                            err_d   = 1'b1;
                            state_d = S_DONE;
`endif
                        end else begin
                            state_d   = S_LOAD;
                            s_ready_d = 1'b1;
                        end
                    end
                end
            end
`ifdef SPRITE_LOADER_PAD_EN
            S_PAD: begin
                we_d   = 1'b1;
                addr_d = ptr;
                pix_d  = KEY_C;
                if (ptr == LAST_ADDR) state_d = S_DONE;
                else                  ptr_d   = ptr + 1'b1;
            end
`endif
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Purpose: randomized and directed frame loads checked against a word-level model of the loader.
// Latency: expects the first write one cycle after the first accepted word, done one cycle after the last write.
// Backpressure: words are offered with random gaps and only advance on s_valid & s_ready.
module tb_sprite_ram_loader;

    localparam int CD    = 12;
    localparam int ADDR  = 11;
    localparam int RUN_W = 5;
    localparam int KEY   = 0;
    localparam int FRAME = 1 << ADDR;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                start = 1'b0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [RUN_W+CD-1:0] s_data = '0;
    logic                s_last = 1'b0;
    logic                we;
    logic [ADDR-1:0]     addr_w;
    logic [CD-1:0]       pixel_out;
    logic                busy, done, err;

    sprite_ram_loader #(.CD(CD), .ADDR(ADDR), .RUN_W(RUN_W), .KEY_COLOR(KEY)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .we(we), .addr_w(addr_w), .pixel_out(pixel_out),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // stimulus words and expected response
    int wr[$];
    int wc[$];
    bit wl[$];
    int exp_addr[$];
    int exp_pix[$];
    int exp_err;

    // observed response
    int got_addr[$];
    int got_pix[$];
    bit mon_en = 1'b0;
    int done_cnt, ready_cnt, ready_after, first_we, last_we, done_cyc, busy_at_done, start_cyc;

    always @(negedge clk) begin
        if (mon_en) begin
            if (we) begin
                got_addr.push_back(int'(addr_w));
                got_pix.push_back(int'(pixel_out));
                if (first_we < 0) first_we = cyc;
                last_we = cyc;
            end
            if (s_ready) begin
                if (done_cnt > 0) ready_after++;
                else              ready_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                busy_at_done = int'(busy);
            end
        end
    end

    // Pixel stream the frame should receive: every word expands to run+1 pixels
    // laid down from address 0; the frame stops hard at the last address.
    function automatic void model();
        int  p = 0;
        bit  ended = 1'b0;
        exp_addr.delete();
        exp_pix.delete();
        exp_err = 0;
        for (int w = 0; w < wr.size() && !ended; w++) begin
            for (int k = 0; k <= wr[w]; k++) begin
                exp_addr.push_back(p);
                exp_pix.push_back(wc[w]);
                if (p == FRAME - 1) begin
                    ended = 1'b1;
                    if (!wl[w] || k < wr[w]) exp_err = 1;
                    break;
                end
                p++;
            end
            if (!ended && wl[w]) begin
                ended = 1'b1;
`ifdef SPRITE_LOADER_PAD_EN
                while (p < FRAME) begin
                    exp_addr.push_back(p);
                    exp_pix.push_back(KEY);
                    p++;
                end
`else
                exp_err = 1;
`endif
            end
        end
    endfunction

    task automatic clear_mon();
        got_addr.delete();
        got_pix.delete();
        done_cnt = 0; ready_cnt = 0; ready_after = 0;
        first_we = -1; last_we = -1; done_cyc = -1; busy_at_done = -1;
    endtask

    task automatic push_word(input int r, input int c, input bit l);
        wr.push_back(r);
        wc.push_back(c);
        wl.push_back(l);
    endtask

    task automatic clear_words();
        wr.delete(); wc.delete(); wl.delete();
    endtask

    // One complete frame load; called at a negedge with the loader idle.
    task automatic run_load(input string name, input int gap_pct, input bit hold_after,
                            input bit poke_start, input bit tight, input int exp_ready);
        int idx = 0;
        int budget = 0;
        int n;
        model();
        clear_mon();
        mon_en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
        chk({name, "_busy_after_start"}, int'(busy), 1);
        chk({name, "_ready_after_start"}, int'(s_ready), 1);
        while (done_cnt == 0 && budget < 8000) begin
            if (idx < wr.size() && $urandom_range(0, 99) >= gap_pct) begin
                s_valid = 1'b1;
                s_data  = {RUN_W'(wr[idx]), CD'(wc[idx])};
                s_last  = wl[idx];
            end else begin
                s_valid = hold_after && (idx >= wr.size());
                s_data  = {RUN_W'(31), CD'(12'h5A5)};
                s_last  = 1'b0;
            end
            start = poke_start && (budget == 40);
            if (s_valid && s_ready) idx++;
            @(negedge clk);
            budget++;
        end
        start = 1'b0;
        chk({name, "_done_seen"}, int'(done_cnt > 0), 1);
        for (int i = 0; i < 5; i++) begin
            s_valid = hold_after;
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        mon_en  = 1'b0;
        n = got_addr.size();
        chk({name, "_nwrites"}, n, exp_addr.size());
        if (n > exp_addr.size()) n = exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk({name, "_addr"}, got_addr[i], exp_addr[i]);
            chk({name, "_pix"}, got_pix[i], exp_pix[i]);
        end
        chk({name, "_err"}, int'(err), exp_err);
        chk({name, "_done_pulses"}, done_cnt, 1);
        chk({name, "_done_after_last_we"}, done_cyc, last_we + 1);
        chk({name, "_busy_at_done"}, busy_at_done, 1);
        chk({name, "_busy_idle"}, int'(busy), 0);
        chk({name, "_ready_after_done"}, ready_after, 0);
        if (tight) begin
            chk({name, "_first_we_lat"}, first_we, start_cyc + 1);
            chk({name, "_we_contiguous"}, last_we - first_we, exp_addr.size() - 1);
        end
        if (exp_ready >= 0) chk({name, "_ready_cycles"}, ready_cnt, exp_ready);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_s_ready"}, int'(s_ready), 0);
        chk({name, "_we"}, int'(we), 0);
        chk({name, "_addr_w"}, int'(addr_w), 0);
        chk({name, "_pixel_out"}, int'(pixel_out), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_err"}, int'(err), 0);
    endtask

    initial begin
        int total;
        int budget;
        bit hit;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // gradient frame, one pixel per word, start poked mid-load
        clear_words();
        for (int i = 0; i < FRAME; i++) push_word(0, i & 12'hFFF, i == FRAME - 1);
        run_load("gradient", 0, 1'b0, 1'b1, 1'b1, FRAME);

        // long runs: input accepted once per 32 cycles
        clear_words();
        for (int i = 0; i < 64; i++) push_word(31, 12'hABC, i == 63);
        run_load("runs", 0, 1'b0, 1'b0, 1'b1, 64);

        // single word ending the frame early
        clear_words();
        push_word(31, 12'hF00, 1'b1);
        run_load("early_last", 0, 1'b0, 1'b0, 1'b1, 1);

        // frame fills without s_last, source keeps offering words
        clear_words();
        for (int i = 0; i < 64; i++) push_word(31, 12'h3C7, 1'b0);
        run_load("no_last", 0, 1'b1, 1'b0, 1'b1, 64);

        // overrun: last word's run crosses the end of the frame
        clear_words();
        for (int i = 0; i < 63; i++) push_word(31, 12'h111, 1'b0);
        push_word(30, 12'h222, 1'b0);
        push_word(5, 12'h333, 1'b1);
        run_load("overrun", 0, 1'b0, 1'b0, 1'b1, 65);

        // reset while expanding at pointer 100
        clear_words();
        for (int i = 0; i < 8; i++) push_word(31, 12'h777, 1'b0);
        clear_mon();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int idx = 0;
            budget = 0;
            hit = 1'b0;
            while (!hit && budget < 500) begin
                if (we && addr_w == ADDR'(99)) begin
                    hit = 1'b1;
                    s_valid = 1'b0;
                end else begin
                    s_valid = idx < wr.size();
                    s_data  = {RUN_W'(wr[idx % wr.size()]), CD'(wc[idx % wc.size()])};
                    s_last  = 1'b0;
                    if (s_valid && s_ready) idx++;
                    @(negedge clk);
                    budget++;
                end
            end
        end
        chk("midreset_reached_ptr100", int'(hit), 1);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset_we_quiet", int'(we), 0);

        // restart after reset must begin at address 0
        clear_words();
        for (int i = 0; i < 40; i++) push_word(i % 32, (i * 97) & 12'hFFF, 1'b0);
        total = 0;
        for (int i = 0; i < 40; i++) total += wr[i] + 1;
        while (total < FRAME) begin
            push_word(31, 12'h0F0, 1'b0);
            total += 32;
        end
        wl[wl.size() - 1] = (total == FRAME);
        run_load("restart", 0, 1'b0, 1'b0, 1'b1, -1);
        if (got_addr.size() > 0) chk("restart_first_addr", got_addr[0], 0);

        // random streams with random source gaps
        for (int t = 0; t < 4; t++) begin
            clear_words();
            total = 0;
            for (int n = 0; n < 4000; n++) begin
                push_word($urandom_range(0, 31), $urandom_range(0, 4095), 1'b0);
                total += wr[wr.size() - 1] + 1;
                if (total >= FRAME || $urandom_range(0, 299) == 0) break;
            end
            wl[wl.size() - 1] = (total >= FRAME) ? 1'($urandom_range(0, 1)) : 1'b1;
            run_load($sformatf("rand%0d", t), 30, 1'b0, 1'b0, 1'b0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
